output_read_scheduler: RTL

OUTPUT_READ_SCHEDULER -- requirements
Module: output_read_scheduler

---
 rtl/output_read_scheduler.sv | 269 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/output_read_scheduler.sv
// rtl/output_read_scheduler.sv - round-robin job scheduler driving the header/BRAM output read path
module output_read_scheduler #(
    parameter int          N_REQ       = 4,
    parameter int          TIMEOUT_CYC = 65535,
    parameter logic [15:0] SYNC_WORD   = 16'hA5A5
) (
    input  logic                  aclk,
    input  logic                  areset,
    input  logic [N_REQ-1:0]      req_valid,
    output logic [N_REQ-1:0]      req_ready,
    input  logic [3*N_REQ-1:0]    req_bram_start,
    input  logic [3*N_REQ-1:0]    req_bram_end,
    input  logic [16*N_REQ-1:0]   req_addr_count,
    input  logic [N_REQ-1:0]      req_notify,
    output logic [2:0]            rd_bram_start,
    output logic [2:0]            rd_bram_end,
    output logic [15:0]           rd_addr_count,
    output logic                  notification_only,
    output logic                  send_header,
    output logic [15:0]           header_word_0,
    output logic [15:0]           header_word_1,
    output logic [15:0]           header_word_2,
    output logic [15:0]           header_word_3,
    output logic [15:0]           header_word_4,
    output logic [15:0]           header_word_5,
    input  logic                  read_done,
    input  logic                  out_tlast_hs,
    output logic [N_REQ-1:0]      done_pulse,
    output logic                  done_err,
    output logic                  busy,
    output logic [2:0]            grant_id,
    output logic [7:0]            seq_num,
    output logic                  err_timeout
);
    localparam int CW = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [2:0] {S_IDLE, S_ARB, S_LOAD, S_TRIG, S_WAIT, S_COOL} state_t;

    state_t             r_state, w_state_nxt;
    logic [2:0]         r_last_grant, r_grant_id;
    logic [2:0]         r_d_start, r_d_end;
    logic [15:0]        r_d_count;
    logic               r_d_notify;
    logic [7:0]         r_seq;
    logic [CW-1:0]      r_wait_cnt;
    logic               r_cool_cnt, r_rd_seen, r_tl_seen, r_err_timeout;
    logic [N_REQ-1:0]   r_req_ready, r_done_pulse;
    logic               r_done_err, r_send_header;
    logic [2:0]         r_rd_start, r_rd_end;
    logic [15:0]        r_rd_count;
    logic               r_rd_notify;
    logic [15:0]        r_hdr1, r_hdr2, r_hdr3, r_hdr4, r_hdr5;

    logic [7:0]         w_valid_ext;
    logic [2:0]         w_start_arr [8];
    logic [2:0]         w_end_arr   [8];
    logic [15:0]        w_count_arr [8];
    logic               w_notify_arr[8];
    logic               w_found, w_job_ok, w_complete;
    logic [2:0]         w_win;
    logic [3:0]         w_idx, w_banks;
    logic [15:0]        w_word1, w_word2, w_word3, w_word4, w_word5;
    logic [N_REQ-1:0]   w_req_ready_nxt, w_done_nxt;
    logic               w_done_err_nxt, w_send_nxt, w_finish, w_timeout;

    // Unpack the flat descriptor buses into 8-entry tables so a 3-bit grant index selects directly
    for (genvar g = 0; g < 8; g++) begin : g_desc
        if (g < N_REQ) begin : g_used
            assign w_valid_ext[g]  = req_valid[g];
            assign w_start_arr[g]  = req_bram_start[g*3 +: 3];
            assign w_end_arr[g]    = req_bram_end[g*3 +: 3];
            assign w_count_arr[g]  = req_addr_count[g*16 +: 16];
            assign w_notify_arr[g] = req_notify[g];
        end else begin : g_unused
            assign w_valid_ext[g]  = 1'b0;
            assign w_start_arr[g]  = '0;
            assign w_end_arr[g]    = '0;
            assign w_count_arr[g]  = '0;
            assign w_notify_arr[g] = 1'b0;
        end
    end

    // Round-robin search starting just after the previous winner
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_idx   = '0;
        for (int i = 1; i <= N_REQ; i++) begin
            w_idx = {1'b0, r_last_grant} + 4'(i);
            if (w_idx >= 4'(N_REQ)) w_idx = w_idx - 4'(N_REQ);
            if (!w_found && w_valid_ext[w_idx[2:0]]) begin
                w_found = 1'b1;
                w_win   = w_idx[2:0];
            end
        end
    end

    // Notification jobs carry no data range, so only data jobs are range/count checked
    assign w_job_ok = w_notify_arr[w_win] ||
                      ((w_end_arr[w_win] >= w_start_arr[w_win]) && (w_count_arr[w_win] != 16'd0));

    assign w_banks = ({1'b0, r_d_end} - {1'b0, r_d_start}) + 4'd1;
    assign w_word1 = {r_seq, 4'b0, r_d_notify, r_grant_id};
    assign w_word2 = {10'b0, r_d_end, r_d_start};
    assign w_word3 = r_d_count;
    assign w_word4 = r_d_notify ? 16'h0000 : 16'(w_banks) * r_d_count;
    assign w_word5 = SYNC_WORD ^ w_word1 ^ w_word2 ^ w_word3 ^ w_word4;

    // A data job needs both the batch read and the final stream beat; each may arrive first
    assign w_complete = r_d_notify ? out_tlast_hs
                                   : ((r_rd_seen | read_done) & (r_tl_seen | out_tlast_hs));

    // FSM state register
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Next state plus next values of the registered handshake pulses
    always_comb begin
        w_state_nxt     = r_state;
        w_req_ready_nxt = '0;
        w_done_nxt      = '0;
        w_done_err_nxt  = 1'b0;
        w_send_nxt      = 1'b0;
        w_finish        = 1'b0;
        w_timeout       = 1'b0;
        case (r_state)
            S_IDLE: if (|req_valid) w_state_nxt = S_ARB;
            S_ARB: begin
                if (!w_found) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_req_ready_nxt = N_REQ'(1) << w_win;
                    if (w_job_ok) begin
                        w_state_nxt = S_LOAD;
                    end else begin
                        w_state_nxt    = S_COOL;
                        w_done_nxt     = N_REQ'(1) << w_win;
                        w_done_err_nxt = 1'b1;
                    end
                end
            end
            S_LOAD: begin
                w_state_nxt = S_TRIG;
                w_send_nxt  = 1'b1;
            end
            S_TRIG: w_state_nxt = S_WAIT;
            S_WAIT: begin
                if (w_complete) begin
                    w_state_nxt = S_COOL;
                    w_done_nxt  = N_REQ'(1) << r_grant_id;
                    w_finish    = 1'b1;
                end else if (r_wait_cnt == CW'(TIMEOUT_CYC - 1)) begin
                    w_state_nxt    = S_COOL;
                    w_done_nxt     = N_REQ'(1) << r_grant_id;
                    w_done_err_nxt = 1'b1;
                    w_finish       = 1'b1;
                    w_timeout      = 1'b1;
                end
            end
            S_COOL: if (r_cool_cnt) w_state_nxt = (|req_valid) ? S_ARB : S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Registered pulses, sequence number and sticky timeout flag
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_req_ready   <= '0;
            r_done_pulse  <= '0;
            r_done_err    <= 1'b0;
            r_send_header <= 1'b0;
            r_seq         <= 8'd0;
            r_err_timeout <= 1'b0;
        end else begin
            r_req_ready   <= w_req_ready_nxt;
            r_done_pulse  <= w_done_nxt;
            r_done_err    <= w_done_err_nxt;
            r_send_header <= w_send_nxt;
            if (w_finish)  r_seq         <= r_seq + 8'd1;
            if (w_timeout) r_err_timeout <= 1'b1;
        end
    end

    // Latch the winner and its descriptor at grant time
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_last_grant <= 3'(N_REQ - 1);
            r_grant_id   <= '0;
            r_d_start    <= '0;
            r_d_end      <= '0;
            r_d_count    <= '0;
            r_d_notify   <= 1'b0;
        end else if (r_state == S_ARB && w_found) begin
            r_last_grant <= w_win;
            r_grant_id   <= w_win;
            r_d_start    <= w_start_arr[w_win];
            r_d_end      <= w_end_arr[w_win];
            r_d_count    <= w_count_arr[w_win];
            r_d_notify   <= w_notify_arr[w_win];
        end
    end

    // Datapath and header outputs are loaded once per job and held until the next job
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_rd_start  <= '0;
            r_rd_end    <= '0;
            r_rd_count  <= '0;
            r_rd_notify <= 1'b0;
            r_hdr1      <= '0;
            r_hdr2      <= '0;
            r_hdr3      <= '0;
            r_hdr4      <= '0;
            r_hdr5      <= '0;
        end else if (r_state == S_LOAD) begin
            r_rd_start  <= r_d_start;
            r_rd_end    <= r_d_end;
            r_rd_count  <= r_d_count;
            r_rd_notify <= r_d_notify;
            r_hdr1      <= w_word1;
            r_hdr2      <= w_word2;
            r_hdr3      <= w_word3;
            r_hdr4      <= w_word4;
            r_hdr5      <= w_word5;
        end
    end

    // WAIT cycle counter and completion flags; anything seen outside WAIT is discarded
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_wait_cnt <= '0;
            r_rd_seen  <= 1'b0;
            r_tl_seen  <= 1'b0;
            r_cool_cnt <= 1'b0;
        end else begin
            if (r_state == S_WAIT) begin
                r_wait_cnt <= r_wait_cnt + CW'(1);
                r_rd_seen  <= r_rd_seen | read_done;
                r_tl_seen  <= r_tl_seen | out_tlast_hs;
            end else begin
                r_wait_cnt <= '0;
                r_rd_seen  <= 1'b0;
                r_tl_seen  <= 1'b0;
            end
            r_cool_cnt <= (r_state == S_COOL) ? ~r_cool_cnt : 1'b0;
        end
    end

    assign req_ready         = r_req_ready;
    assign done_pulse        = r_done_pulse;
    assign done_err          = r_done_err;
    assign send_header       = r_send_header;
    assign busy              = (r_state != S_IDLE);
    assign grant_id          = r_grant_id;
    assign seq_num           = r_seq;
    assign err_timeout       = r_err_timeout;
    assign rd_bram_start     = r_rd_start;
    assign rd_bram_end       = r_rd_end;
    assign rd_addr_count     = r_rd_count;
    assign notification_only = r_rd_notify;
    assign header_word_0     = SYNC_WORD;
    assign header_word_1     = r_hdr1;
    assign header_word_2     = r_hdr2;
    assign header_word_3     = r_hdr3;
    assign header_word_4     = r_hdr4;
    assign header_word_5     = r_hdr5;
endmodule
